// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer driving one external full-adder cell, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic [1:0]       dbg_state
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid-side data is held stable until that edge, ready never waits on valid.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= in_a;
            b_sh     <= in_b;
            carry    <= in_cin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // The sum register fills from the top so bit 0 lands last at the LSB.
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          carry  <= fa_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
            ovf       <= carry ^ fa_cout;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state == RUN) begin
      fa_a   = a_sh[0];
      fa_b   = b_sh[0];
      fa_cin = carry;
    end
  end

  assign out_sum   = sum_sh;
  assign out_cout  = carry;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: vector table, hand-written corner sequences and a
// result scoreboard. ovf checks are compiled in only with SERIAL_ADD_OVF_EN.
module tb_serial_add_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_cin;
  logic         out_valid, out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout, busy;
  logic         fa_a, fa_b, fa_cin, fa_s, fa_cout;
  logic [1:0]   dbg_state;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_s(fa_s), .fa_cout(fa_cout),
    .dbg_state(dbg_state)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  // Shared full-adder cell.
  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int acc_cyc = 0;
  logic ov_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops on each result handshake; also checks accept-to-valid latency.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && !ov_q) chk("latency", cyc - acc_cyc, W + 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_result: got %0h expected none", {out_cout, out_sum});
        end else begin
          chk("result", {out_cout, out_sum}, exp_q.pop_front());
        end
      end
    end
    ov_q <= out_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic keep);
    int n = 0;
    logic [W:0] e;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("accept_timeout", 32'd1, 32'd0);
    end else begin
      e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      exp_q.push_back(e);
      acc_cyc = cyc;
    end
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [3:0] exp_fa;
    logic [3:0] exp_fb;
    int prev_acc;
    int n;
    logic saw;

    vecs[0] = '{4'h5, 4'h3, 1'b0, 4'h8, 1'b0};
    vecs[1] = '{4'hF, 4'h1, 1'b1, 4'h1, 1'b1};
    vecs[2] = '{4'h6, 4'h9, 1'b0, 4'hF, 1'b0};
    vecs[3] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
    vecs[4] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    vecs[5] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1};
    vecs[6] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1};
    vecs[7] = '{4'h7, 4'h7, 1'b0, 4'hE, 1'b0};
    vecs[8] = '{4'h3, 4'hC, 1'b1, 4'h0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_fa", {fa_a, fa_b, fa_cin}, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif

    // Basic add with serial operand sequence
    send(4'h5, 4'h3, 1'b0, 1'b0);
    exp_fa = 4'b0101;
    exp_fb = 4'b0011;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("fa_a_seq", fa_a, exp_fa[k]);
      chk("fa_b_seq", fa_b, exp_fb[k]);
      chk("run_busy", busy, 1);
    end
    drain();
    chk("idle_fa", {fa_a, fa_b, fa_cin}, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf_5p3", ovf, 1);
`endif

    // Carry chain
    send(4'hF, 4'h1, 1'b1, 1'b0);
    drain();
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf_fp1", ovf, 0);
`endif

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
      drain();
      chk("table_sum", out_sum, vecs[i].sum);
      chk("table_cout", out_cout, vecs[i].cout);
    end

    // Backpressure with ignored operand pulses
    @(posedge clk); #1 out_ready = 1'b0;
    send(4'h6, 4'h9, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_rise", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_sum_hold", out_sum, 4'hF);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
      in_valid = (i % 2 == 0); in_a = 4'h1; in_b = 4'h1; in_cin = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    drain();
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    chk("bp_no_second", saw, 0);

    // Reset during the third RUN cycle
    send(4'h3, 4'h3, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sum", out_sum, 0);
    send(4'h7, 4'h7, 1'b0, 1'b0);
    drain();
    chk("post_rst_sum", out_sum, 4'hE);
    chk("post_rst_cout", out_cout, 0);

    // Back-to-back with in_valid held
    prev_acc = 0;
    for (int i = 0; i < 10; i++) begin
      send(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'b1);
      if (i > 0) chk("b2b_spacing", acc_cyc - prev_acc, W + 2);
      prev_acc = acc_cyc;
    end
    in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
